pipelined_adder: RTL

// - Parametrised, pipelined ripple-carry adder/subtractor; successor to the single-bit full adder.
// - Splits a WIDTH-bit add into STAGES slices. Each slice adds WIDTH/STAGES bits per cycle and registers the carry into the next slice.
// - Valid/ready streaming on both sides. Used in datapaths where a single-cycle WIDTH-bit carry chain misses timing.

---
 rtl/adder_pkg.sv | 15 +
 rtl/adder_slice.sv | 24 ++
 rtl/pipelined_adder.sv | 130 +++++++++++++
 3 files changed

// File: rtl/adder_pkg.sv
// Shared sizing helpers and defaults for the pipelined adder family.
package adder_pkg;

  localparam int ADD_WIDTH_DEF  = 32;
  localparam int ADD_STAGES_DEF = 4;

  function automatic int slice_w(input int width, input int stages);
    return width / stages;
  endfunction

  function automatic bit split_ok(input int width, input int stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/adder_slice.sv
// SW-bit combinational ripple-carry slice: {c_o, sum_o} = a_i + b_i + c_i.
module adder_slice #(
  parameter int SW = 8
) (
  input  logic [SW-1:0] a_i,
  input  logic [SW-1:0] b_i,
  input  logic          c_i,
  output logic [SW-1:0] sum_o,
  output logic          c_o
);

  logic [SW:0] c;

  always_comb begin
    c    = '0;
    c[0] = c_i;
    for (int i = 0; i < SW; i++) begin
      sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
      c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end
    c_o = c[SW];
  end

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined ripple-carry adder/subtractor, one SW-bit slice per stage, valid/ready both sides.
// Optional signed-overflow output enabled by defining PIPELINED_ADDER_OVF_EN.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = ADD_WIDTH_DEF,
  parameter int STAGES = ADD_STAGES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry
`ifdef PIPELINED_ADDER_OVF_EN
  ,
  output logic             out_ovf
`endif
);

  localparam int SW = slice_w(WIDTH, STAGES);

  if (!split_ok(WIDTH, STAGES)) begin : g_bad_cfg
    $error("pipelined_adder: WIDTH must be a multiple of STAGES and STAGES in 1..WIDTH");
  end

  logic [STAGES-1:0] vld_pipe_q;
  logic [STAGES:0]   vld_cat;
  logic [STAGES:0]   load;

  assign vld_cat = {vld_pipe_q, in_valid};

  // Ready ripples back from the sink; an empty stage always accepts, collapsing bubbles.
  always_comb begin
    load         = '0;
    load[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) load[k] = !vld_pipe_q[k] || load[k+1];
  end

  assign in_ready = load[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_pipe_q <= '0;
    else begin
      for (int k = 0; k < STAGES; k++)
        if (load[k]) vld_pipe_q[k] <= vld_cat[k];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    // Operands shrink by one slice per stage; finished sum bits grow by one slice.
    localparam int RW = WIDTH - k * SW;

    logic [RW-1:0]       a_in, b_in;
    logic                c_in;
    logic [SW-1:0]       s;
    logic                c_out;
    logic [(k+1)*SW-1:0] sum_d, sum_q;
    logic                c_q;

    if (k == 0) begin : g_src
      assign a_in  = in_a;
      assign b_in  = in_b ^ {WIDTH{in_sub}};
      assign c_in  = in_sub | in_cin;
      assign sum_d = s;
    end else begin : g_src
      assign a_in  = g_stg[k-1].g_fwd.a_q;
      assign b_in  = g_stg[k-1].g_fwd.b_q;
      assign c_in  = g_stg[k-1].c_q;
      assign sum_d = {s, g_stg[k-1].sum_q};
    end

    adder_slice #(.SW(SW)) u_slice (
      .a_i   (a_in[SW-1:0]),
      .b_i   (b_in[SW-1:0]),
      .c_i   (c_in),
      .sum_o (s),
      .c_o   (c_out)
    );

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sum_q <= '0;
        c_q   <= 1'b0;
      end else if (load[k]) begin
        sum_q <= sum_d;
        c_q   <= c_out;
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      logic [RW-SW-1:0] a_q, b_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (load[k]) begin
          a_q <= a_in[RW-1:SW];
          b_q <= b_in[RW-1:SW];
        end
      end
    end

`ifdef PIPELINED_ADDER_OVF_EN
    // Operand MSBs reach the last stage with the op, so overflow aligns with the sum.
    if (k == STAGES - 1) begin : g_ovf
      logic ovf_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) ovf_q <= 1'b0;
        else if (load[k])
          ovf_q <= (a_in[SW-1] == b_in[SW-1]) && (s[SW-1] != a_in[SW-1]);
      end
    end
`endif
  end

  assign out_valid = vld_cat[STAGES];
  assign out_sum   = g_stg[STAGES-1].sum_q;
  assign out_carry = g_stg[STAGES-1].c_q;
`ifdef PIPELINED_ADDER_OVF_EN
  assign out_ovf   = g_stg[STAGES-1].g_ovf.ovf_q;
`endif

endmodule
